// File: rtl/node_state_mgr.sv
// node_state_mgr: per-node cluster state keeper.
// Tracks sink distance, cluster-head role, TDMA slot, Q-value and a
// low-energy flag, sequenced by an IDLE/SETUP/COMM/RECL state machine.
// Optional feature macro: SOS_RECLUSTER_EN (SOS in COMM forces re-clustering
// via RECL; without it an HB in COMM re-enters SETUP directly).
// Packet interface: en_MNI is a one-cycle valid strobe with no ready; the
// node always consumes the packet on the rising edge where en_MNI is high,
// and the payload fields are don't-care while it is low.
module node_state_mgr #(
  parameter int                WORD_W       = 16,
  parameter logic [WORD_W-1:0] NODE_ID      = 'h000C,
  parameter int                LOCK_TIMEOUT = 1024,
  parameter int                E_HYST       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_MNI,
  input  logic [2:0]        fPktType,
  input  logic [WORD_W-1:0] hops,
  input  logic [WORD_W-1:0] ch_ID,
  input  logic [WORD_W-1:0] timeslot,
  input  logic [WORD_W-1:0] e_threshold,
  input  logic [WORD_W-1:0] energy,
  input  logic [WORD_W-1:0] q_in,
  input  logic              q_valid,
  output logic [WORD_W-1:0] myNodeID,
  output logic [WORD_W-1:0] hopsFromSink,
  output logic [WORD_W-1:0] myQValue,
  output logic [WORD_W-1:0] myTimeslot,
  output logic              role,
  output logic              low_E,
  output logic              hb_accept,
  output logic [1:0]        node_state
);

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_TS   = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  // Last lock-timer value before SETUP gives up and falls back to IDLE.
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_COMM  = 2'b10,
    S_RECL  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lock_cnt;
  logic [WORD_W-1:0]   thr_q;
  logic [WORD_W:0]     thr_sum;
  logic [WORD_W-1:0]   thr_hi;
  logic                is_hb, is_che, is_ts, is_data;
  logic                hb_take, che_hit, ts_take, lock_expire;

  assign is_hb   = en_MNI && (fPktType == PKT_HB);
  assign is_che  = en_MNI && (fPktType == PKT_CHE);
  assign is_ts   = en_MNI && (fPktType == PKT_TS);
  assign is_data = en_MNI && (fPktType == PKT_DATA);

`ifdef SOS_RECLUSTER_EN
  localparam logic [2:0] PKT_SOS = 3'b110;
  logic is_sos;
  assign is_sos = en_MNI && (fPktType == PKT_SOS);
`endif

  assign myNodeID   = NODE_ID;
  assign node_state = state_q;

  // Upper release bound for low_E, saturated at the all-ones word.
  assign thr_sum = {1'b0, thr_q} + (WORD_W + 1)'(E_HYST);
  assign thr_hi  = thr_sum[WORD_W] ? '1 : thr_sum[WORD_W-1:0];

  // Next-state and per-cycle register enables from the decoded packet.
  always_comb begin
    state_d     = state_q;
    hb_take     = 1'b0;
    che_hit     = 1'b0;
    ts_take     = 1'b0;
    lock_expire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_hb) begin
          hb_take = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (is_che && (ch_ID == NODE_ID)) che_hit = 1'b1;
        if (is_ts) ts_take = 1'b1;
        // DATA on the terminal-count cycle still wins over the timeout.
        if (is_data) begin
          state_d = S_COMM;
        end else if (lock_cnt == LOCK_LAST) begin
          lock_expire = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_COMM: begin
        if (is_ts) ts_take = 1'b1;
`ifdef SOS_RECLUSTER_EN
        if (is_sos) state_d = S_RECL;
`else
        if (is_hb) begin
          hb_take = 1'b1;
          state_d = S_SETUP;
        end
`endif
      end
      default: begin
`ifdef SOS_RECLUSTER_EN
        if (is_hb) begin
          hb_take = 1'b1;
          state_d = S_SETUP;
        end
`else
        // RECL cannot be entered in this build; recover to IDLE if seen.
        state_d = S_IDLE;
`endif
      end
    endcase
  end

  // State register and SETUP lock timer (zero outside SETUP and on entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lock_cnt <= '0;
    end else begin
      state_q  <= state_d;
      lock_cnt <= ((state_q == S_SETUP) && (state_d == S_SETUP)) ? lock_cnt + 16'd1 : '0;
    end
  end

  // Node information captured from HB, CHE and TS packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      hopsFromSink <= '0;
      thr_q        <= '0;
      role         <= 1'b0;
      myTimeslot   <= '0;
      hb_accept    <= 1'b0;
    end else begin
      hb_accept <= hb_take;
      if (hb_take) begin
        hopsFromSink <= hops;
        thr_q        <= e_threshold;
        role         <= 1'b0;
        myTimeslot   <= '0;
      end else begin
        if (che_hit)     role       <= 1'b1;
        if (lock_expire) role       <= 1'b0;
        if (ts_take)     myTimeslot <= timeslot;
      end
    end
  end

  // Q-value load, independent of state and packet traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      myQValue <= '0;
    end else if (q_valid) begin
      myQValue <= q_in;
    end
  end

  // Low-energy flag with hysteresis between threshold and threshold+E_HYST.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_E <= 1'b0;
    end else if (energy < thr_q) begin
      low_E <= 1'b1;
    end else if (energy >= thr_hi) begin
      low_E <= 1'b0;
    end
  end

endmodule

// File: tb/tb_node_state_mgr.sv
// tb_node_state_mgr: directed checks for node_state_mgr (LOCK_TIMEOUT=8).
// Honours SOS_RECLUSTER_EN to select which COMM behaviour is expected.
module tb_node_state_mgr;

  localparam logic [2:0] T_HB   = 3'b000;
  localparam logic [2:0] T_CHE  = 3'b001;
  localparam logic [2:0] T_BAD  = 3'b011;
  localparam logic [2:0] T_TS   = 3'b100;
  localparam logic [2:0] T_DATA = 3'b101;
  localparam logic [2:0] T_SOS  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic [15:0] hops, ch_ID, timeslot, e_threshold, energy, q_in;
  logic        q_valid;
  logic [15:0] myNodeID, hopsFromSink, myQValue, myTimeslot;
  logic        role, low_E, hb_accept;
  logic [1:0]  node_state;

  int total = 0;
  int bad   = 0;

  node_state_mgr #(.LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en_MNI(en_MNI), .fPktType(fPktType),
    .hops(hops), .ch_ID(ch_ID), .timeslot(timeslot), .e_threshold(e_threshold),
    .energy(energy), .q_in(q_in), .q_valid(q_valid),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .myTimeslot(myTimeslot), .role(role), .low_E(low_E), .hb_accept(hb_accept),
    .node_state(node_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Every driver task starts and ends on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en_MNI = 1'b0; fPktType = 3'b111; hops = '0; ch_ID = '0;
    timeslot = '0; e_threshold = '0; energy = 16'd200; q_in = '0; q_valid = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic pkt(input logic [2:0] t, input logic [15:0] h, input logic [15:0] c,
                     input logic [15:0] s, input logic [15:0] e);
    fPktType = t; hops = h; ch_ID = c; timeslot = s; e_threshold = e; en_MNI = 1'b1;
    @(negedge clk);
    en_MNI = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (node_state !== 2'b00) begin bad++; $display("FAIL rst_state: got %0h want 0", node_state); end
    total++; if (myNodeID !== 16'h000C) begin bad++; $display("FAIL rst_id: got %0h want c", myNodeID); end
    total++; if ({hopsFromSink, myQValue, myTimeslot} !== 48'd0) begin bad++; $display("FAIL rst_regs: got %0h want 0", {hopsFromSink, myQValue, myTimeslot}); end
    total++; if ({role, low_E, hb_accept} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %0b want 000", {role, low_E, hb_accept}); end
  endtask

  task automatic test_hb();
    do_reset();
    pkt(T_HB, 16'd3, 16'd0, 16'd0, 16'd100);
    total++; if (hopsFromSink !== 16'd3) begin bad++; $display("FAIL hb_hops: got %0d want 3", hopsFromSink); end
    total++; if (node_state !== 2'b01) begin bad++; $display("FAIL hb_state: got %0h want 1", node_state); end
    total++; if (hb_accept !== 1'b1) begin bad++; $display("FAIL hb_pulse: got %0b want 1", hb_accept); end
    idle(1);
    total++; if (hb_accept !== 1'b0) begin bad++; $display("FAIL hb_pulse_end: got %0b want 0", hb_accept); end
    pkt(T_HB, 16'd7, 16'd0, 16'd0, 16'd50);
    total++; if (hopsFromSink !== 16'd3) begin bad++; $display("FAIL hb2_hops: got %0d want 3", hopsFromSink); end
    total++; if (hb_accept !== 1'b0) begin bad++; $display("FAIL hb2_pulse: got %0b want 0", hb_accept); end
  endtask

  task automatic test_che_ts();
    do_reset();
    pkt(T_HB, 16'd3, 16'd0, 16'd0, 16'd100);
    pkt(T_BAD, 16'd0, 16'h000C, 16'd0, 16'd0);
    total++; if (role !== 1'b0) begin bad++; $display("FAIL bad_type_role: got %0b want 0", role); end
    pkt(T_CHE, 16'd0, 16'h000C, 16'd0, 16'd0);
    total++; if (role !== 1'b1) begin bad++; $display("FAIL che_own: got %0b want 1", role); end
    pkt(T_CHE, 16'd0, 16'h0005, 16'd0, 16'd0);
    total++; if (role !== 1'b1) begin bad++; $display("FAIL che_other: got %0b want 1", role); end
    pkt(T_TS, 16'd0, 16'd0, 16'd9, 16'd0);
    total++; if (myTimeslot !== 16'd9) begin bad++; $display("FAIL ts_setup: got %0d want 9", myTimeslot); end
  endtask

  task automatic test_timeout();
    do_reset();
    pkt(T_HB, 16'd4, 16'd0, 16'd0, 16'd100);
    pkt(T_CHE, 16'd0, 16'h000C, 16'd0, 16'd0);
    idle(6);
    total++; if (node_state !== 2'b01 || role !== 1'b1) begin bad++; $display("FAIL to_before: got %0h/%0b want 1/1", node_state, role); end
    idle(1);
    total++; if (node_state !== 2'b00) begin bad++; $display("FAIL to_state: got %0h want 0", node_state); end
    total++; if (role !== 1'b0) begin bad++; $display("FAIL to_role: got %0b want 0", role); end
    total++; if (hopsFromSink !== 16'd4) begin bad++; $display("FAIL to_hops: got %0d want 4", hopsFromSink); end
  endtask

  task automatic test_data_terminal();
    do_reset();
    pkt(T_HB, 16'd1, 16'd0, 16'd0, 16'd100);
    idle(7);
    total++; if (node_state !== 2'b01) begin bad++; $display("FAIL term_before: got %0h want 1", node_state); end
    pkt(T_DATA, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b10) begin bad++; $display("FAIL term_data: got %0h want 2", node_state); end
    idle(10);
    total++; if (node_state !== 2'b10) begin bad++; $display("FAIL comm_hold: got %0h want 2", node_state); end
    pkt(T_DATA, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b10) begin bad++; $display("FAIL comm_data: got %0h want 2", node_state); end
    pkt(T_TS, 16'd0, 16'd0, 16'd5, 16'd0);
    total++; if (myTimeslot !== 16'd5) begin bad++; $display("FAIL ts_comm: got %0d want 5", myTimeslot); end
  endtask

  task automatic test_low_energy();
    logic [15:0] e_seq [4] = '{16'd120, 16'd99, 16'd110, 16'd116};
    logic        l_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    energy = 16'd120;
    pkt(T_HB, 16'd1, 16'd0, 16'd0, 16'd100);
    for (int i = 0; i < 4; i++) begin
      energy = e_seq[i];
      @(negedge clk);
      total++; if (low_E !== l_seq[i]) begin bad++; $display("FAIL low_e[%0d]: got %0b want %0b", i, low_E, l_seq[i]); end
    end
    do_reset();
    energy = 16'hFFFF;
    pkt(T_HB, 16'd1, 16'd0, 16'd0, 16'hFFF8);
    energy = 16'hFFF0; @(negedge clk);
    total++; if (low_E !== 1'b1) begin bad++; $display("FAIL sat_set: got %0b want 1", low_E); end
    energy = 16'hFFFE; @(negedge clk);
    total++; if (low_E !== 1'b1) begin bad++; $display("FAIL sat_hold: got %0b want 1", low_E); end
    energy = 16'hFFFF; @(negedge clk);
    total++; if (low_E !== 1'b0) begin bad++; $display("FAIL sat_clear: got %0b want 0", low_E); end
  endtask

  task automatic test_qvalue();
    do_reset();
    q_in = 16'h1234; q_valid = 1'b1;
    @(negedge clk);
    total++; if (myQValue !== 16'h1234) begin bad++; $display("FAIL q_load: got %0h want 1234", myQValue); end
    q_in = 16'h5555; q_valid = 1'b0;
    @(negedge clk);
    total++; if (myQValue !== 16'h1234) begin bad++; $display("FAIL q_hold: got %0h want 1234", myQValue); end
  endtask

  task automatic test_comm_hb_sos();
    do_reset();
    pkt(T_HB, 16'd5, 16'd0, 16'd0, 16'd100);
    pkt(T_CHE, 16'd0, 16'h000C, 16'd0, 16'd0);
    pkt(T_TS, 16'd0, 16'd0, 16'd4, 16'd0);
    pkt(T_DATA, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b10 || role !== 1'b1) begin bad++; $display("FAIL comm_entry: got %0h/%0b want 2/1", node_state, role); end
`ifdef SOS_RECLUSTER_EN
    pkt(T_HB, 16'd9, 16'd0, 16'd0, 16'd100);
    total++; if (node_state !== 2'b10 || hopsFromSink !== 16'd5) begin bad++; $display("FAIL comm_hb_ign: got %0h/%0d want 2/5", node_state, hopsFromSink); end
    pkt(T_SOS, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b11) begin bad++; $display("FAIL sos_recl: got %0h want 3", node_state); end
    pkt(T_DATA, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b11) begin bad++; $display("FAIL recl_data: got %0h want 3", node_state); end
`else
    pkt(T_SOS, 16'd0, 16'd0, 16'd0, 16'd0);
    total++; if (node_state !== 2'b10) begin bad++; $display("FAIL sos_ign: got %0h want 2", node_state); end
`endif
    pkt(T_HB, 16'd2, 16'd0, 16'd0, 16'd100);
    total++; if (node_state !== 2'b01) begin bad++; $display("FAIL rehb_state: got %0h want 1", node_state); end
    total++; if (hopsFromSink !== 16'd2) begin bad++; $display("FAIL rehb_hops: got %0d want 2", hopsFromSink); end
    total++; if (role !== 1'b0 || myTimeslot !== 16'd0) begin bad++; $display("FAIL rehb_clear: got %0b/%0d want 0/0", role, myTimeslot); end
    total++; if (hb_accept !== 1'b1) begin bad++; $display("FAIL rehb_pulse: got %0b want 1", hb_accept); end
  endtask

  task automatic test_reset_mid_setup();
    do_reset();
    pkt(T_HB, 16'd3, 16'd0, 16'd0, 16'd100);
    pkt(T_CHE, 16'd0, 16'h000C, 16'd0, 16'd0);
    pkt(T_TS, 16'd0, 16'd0, 16'd7, 16'd0);
    q_in = 16'd77; q_valid = 1'b1; energy = 16'd50;
    @(negedge clk);
    q_valid = 1'b0;
    total++; if ({role, low_E, node_state} !== 4'b1101) begin bad++; $display("FAIL mid_pre: got %0b want 1101", {role, low_E, node_state}); end
    rst = 1'b1;
    pkt(T_CHE, 16'd0, 16'h000C, 16'd0, 16'd0);
    total++; if (node_state !== 2'b00) begin bad++; $display("FAIL mid_state: got %0h want 0", node_state); end
    total++; if ({hopsFromSink, myQValue, myTimeslot} !== 48'd0) begin bad++; $display("FAIL mid_regs: got %0h want 0", {hopsFromSink, myQValue, myTimeslot}); end
    total++; if ({role, low_E, hb_accept} !== 3'b000) begin bad++; $display("FAIL mid_flags: got %0b want 000", {role, low_E, hb_accept}); end
    total++; if (myNodeID !== 16'h000C) begin bad++; $display("FAIL mid_id: got %0h want c", myNodeID); end
    rst = 1'b0;
    energy = 16'd200;
    idle(1);
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_hb();
    test_che_ts();
    test_timeout();
    test_data_terminal();
    test_low_energy();
    test_qvalue();
    test_comm_hb_sos();
    test_reset_mid_setup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
